// File: rtl/regfile_port_ctrl.sv
// Write/display port arbiter for the 32x32 register file: post-reset clear, core pass-through,
// 4-phase debug access and board display scanning. Define REGFILE_INIT_EN to enable the clear.
module regfile_port_ctrl #(
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SCAN_DIV = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_regWrite,
    input  logic [ADDR_W-1:0] core_rd,
    input  logic [DATA_W-1:0] core_writeData,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              rf_regWrite,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_writeData,
    output logic [ADDR_W-1:0] rf_displaySelect,
    input  logic [DATA_W-1:0] rf_displayData,
    input  logic              scan_en,
    input  logic [ADDR_W-1:0] manual_select,
    output logic [ADDR_W-1:0] display_index,
    output logic              init_done
);

    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [ScanW-1:0] ScanMax = ScanW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {StInit, StRun, StDbgAcc, StDbgWait} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] init_cnt_q;
    logic [ScanW-1:0]  scan_cnt_q;
    logic [ADDR_W-1:0] scan_idx_q;
    logic              scan_en_q;

    always_comb begin
        core_stall       = 1'b0;
        rf_regWrite      = core_regWrite;
        rf_rd            = core_rd;
        rf_writeData     = core_writeData;
        rf_displaySelect = scan_en ? scan_idx_q : manual_select;
        unique case (state_q)
            StInit: begin
                core_stall   = 1'b1;
                rf_regWrite  = 1'b1;
                rf_rd        = init_cnt_q;
                rf_writeData = '0;
            end
            StDbgAcc: begin
                core_stall       = 1'b1;
                rf_displaySelect = dbg_addr;
                // x0 is never written, but the access is still acknowledged
                rf_regWrite      = dbg_we && (dbg_addr != '0);
                rf_rd            = dbg_addr;
                rf_writeData     = dbg_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef REGFILE_INIT_EN
            state_q <= StInit;
`else
            state_q <= StRun;
`endif
            init_cnt_q    <= ADDR_W'(1);
            scan_cnt_q    <= '0;
            scan_idx_q    <= '0;
            scan_en_q     <= 1'b0;
            dbg_ack       <= 1'b0;
            dbg_rdata     <= '0;
            display_index <= '0;
            init_done     <= 1'b0;
        end else begin
            dbg_ack   <= 1'b0;
            scan_en_q <= scan_en;
`ifndef REGFILE_INIT_EN
            init_done <= 1'b1;
`endif
            if (state_q != StInit) begin
                if (scan_en_q && !scan_en) begin
                    scan_cnt_q <= '0;
                    scan_idx_q <= '0;
                end else if (scan_cnt_q == ScanMax) begin
                    scan_cnt_q <= '0;
                    scan_idx_q <= scan_idx_q + ADDR_W'(1);
                end else begin
                    scan_cnt_q <= scan_cnt_q + ScanW'(1);
                end
            end
            if (state_q == StRun || state_q == StDbgWait) begin
                display_index <= rf_displaySelect;
            end
            unique case (state_q)
                StInit: begin
                    init_cnt_q <= init_cnt_q + ADDR_W'(1);
                    if (init_cnt_q == '1) begin
                        state_q   <= StRun;
                        init_done <= 1'b1;
                    end
                end
                StRun: begin
                    if (dbg_req) state_q <= StDbgAcc;
                end
                StDbgAcc: begin
                    // Display port points at dbg_addr, so this is the pre-write value
                    dbg_rdata <= rf_displayData;
                    dbg_ack   <= 1'b1;
                    state_q   <= StDbgWait;
                end
                StDbgWait: begin
                    if (!dbg_req) state_q <= StRun;
                end
                default: state_q <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Directed bench for regfile_port_ctrl with a behavioural 32x32 register file attached.
module tb_regfile_port_ctrl;

`ifdef REGFILE_INIT_EN
    localparam int InitCycles = 31;
`else
    localparam int InitCycles = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        core_regWrite;
    logic [4:0]  core_rd;
    logic [31:0] core_writeData;
    logic        core_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        rf_regWrite;
    logic [4:0]  rf_rd;
    logic [31:0] rf_writeData;
    logic [4:0]  rf_displaySelect;
    logic [31:0] rf_displayData;
    logic        scan_en;
    logic [4:0]  manual_select;
    logic [4:0]  display_index;
    logic        init_done;

    logic        preload;
    logic [31:0] rf_mem [32];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_port_ctrl #(
        .ADDR_W  (5),
        .DATA_W  (32),
        .SCAN_DIV(4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .core_regWrite   (core_regWrite),
        .core_rd         (core_rd),
        .core_writeData  (core_writeData),
        .core_stall      (core_stall),
        .dbg_req         (dbg_req),
        .dbg_we          (dbg_we),
        .dbg_addr        (dbg_addr),
        .dbg_wdata       (dbg_wdata),
        .dbg_ack         (dbg_ack),
        .dbg_rdata       (dbg_rdata),
        .rf_regWrite     (rf_regWrite),
        .rf_rd           (rf_rd),
        .rf_writeData    (rf_writeData),
        .rf_displaySelect(rf_displaySelect),
        .rf_displayData  (rf_displayData),
        .scan_en         (scan_en),
        .manual_select   (manual_select),
        .display_index   (display_index),
        .init_done       (init_done)
    );

    // Register file: x0 hard-wired to zero, combinational display read
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= (i == 0) ? 32'h0 : (32'h1000_0000 | i);
        end else if (rf_regWrite && rf_rd != 5'd0) begin
            rf_mem[rf_rd] <= rf_writeData;
        end
    end
    assign rf_displayData = rf_mem[rf_displaySelect];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full 4-phase access; returns captured data and the write enable seen in DBG_ACC
    task automatic dbg_access(input string tag, input logic we, input logic [4:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output logic acc_we);
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = addr;
        dbg_wdata = wdata;
        @(negedge clk);
        check({tag, "_stall_acc"}, 32'(core_stall), 32'd1);
        check({tag, "_ack_early"}, 32'(dbg_ack), 32'd0);
        acc_we = rf_regWrite;
        @(negedge clk);
        check({tag, "_ack"}, 32'(dbg_ack), 32'd1);
        check({tag, "_stall_wait"}, 32'(core_stall), 32'd0);
        rdata   = dbg_rdata;
        dbg_req = 1'b0;
        @(negedge clk);
        check({tag, "_ack_drop"}, 32'(dbg_ack), 32'd0);
    endtask

    initial begin
        int stall_cnt;
        int order_ok;
        int j;
        int acks;
        logic [31:0] rdata;
        logic        acc_we;

        rst            = 1'b1;
        preload        = 1'b1;
        core_regWrite  = 1'b0;
        core_rd        = 5'd0;
        core_writeData = 32'h0;
        dbg_req        = 1'b0;
        dbg_we         = 1'b0;
        dbg_addr       = 5'd0;
        dbg_wdata      = 32'h0;
        scan_en        = 1'b1;
        manual_select  = 5'd0;

        repeat (2) @(negedge clk);
        preload = 1'b0;
        @(negedge clk);
        check("rst_ack", 32'(dbg_ack), 32'd0);
        check("rst_rdata", dbg_rdata, 32'd0);
        check("rst_disp", 32'(display_index), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);

        // Release reset: clear sequence (if built in), then display scan at SCAN_DIV = 4
        rst       = 1'b0;
        stall_cnt = 0;
        order_ok  = 0;
        for (int k = 1; k <= InitCycles + 130; k++) begin
            if (k == 1) check("stall_after_rst", 32'(core_stall), 32'(InitCycles > 0));
            if (core_stall) begin
                stall_cnt++;
                if (rf_regWrite && 32'(rf_rd) == stall_cnt && rf_writeData == 32'h0) order_ok++;
            end
            @(negedge clk);
            if (k == ((InitCycles > 0) ? InitCycles : 1))
                check("init_done_rise", 32'(init_done), 32'd1);
            if (InitCycles > 1 && k == InitCycles - 1)
                check("init_done_early", 32'(init_done), 32'd0);
            j = k - InitCycles;
            if (j == 1 || j == 4 || j == 5 || j == 8 || j == 9 || j == 128 || j == 129)
                check($sformatf("scan_j%0d", j), 32'(display_index), 32'(((j - 1) / 4) % 32));
        end
        check("stall_cycles", 32'(stall_cnt), 32'(InitCycles));
        check("clear_order", 32'(order_ok), 32'(InitCycles));

        // Core write-back pass-through
        core_regWrite  = 1'b1;
        core_rd        = 5'd7;
        core_writeData = 32'hDEAD_BEEF;
        #1;
        check("core_we", 32'(rf_regWrite), 32'd1);
        check("core_rd", 32'(rf_rd), 32'd7);
        check("core_wd", rf_writeData, 32'hDEAD_BEEF);
        @(negedge clk);
        core_rd        = 5'd3;
        core_writeData = 32'h0000_00A5;
        @(negedge clk);
        core_regWrite = 1'b0;

        dbg_access("rd7", 1'b0, 5'd7, 32'h0, rdata, acc_we);
        check("rd7_data", rdata, 32'hDEAD_BEEF);
        dbg_access("rd5", 1'b0, 5'd5, 32'h0, rdata, acc_we);
        check("rd5_data", rdata, (InitCycles > 0) ? 32'h0 : 32'h1000_0005);

        dbg_access("wr3", 1'b1, 5'd3, 32'h1234_5678, rdata, acc_we);
        check("wr3_old", rdata, 32'h0000_00A5);
        check("wr3_we", 32'(acc_we), 32'd1);
        dbg_access("rd3", 1'b0, 5'd3, 32'h0, rdata, acc_we);
        check("rd3_data", rdata, 32'h1234_5678);

        dbg_access("wr0", 1'b1, 5'd0, 32'hFFFF_FFFF, rdata, acc_we);
        check("wr0_we", 32'(acc_we), 32'd0);
        dbg_access("rd0", 1'b0, 5'd0, 32'h0, rdata, acc_we);
        check("rd0_data", rdata, 32'h0);

        // A request held high is served once only
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = 5'd7;
        acks     = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dbg_ack) acks++;
        end
        dbg_req = 1'b0;
        repeat (2) @(negedge clk);
        check("held_req_acks", 32'(acks), 32'd1);

        // Manual display select
        scan_en       = 1'b0;
        manual_select = 5'd9;
        repeat (2) @(negedge clk);
        check("manual_disp", 32'(display_index), 32'd9);

        // Reset during DBG_ACC aborts the access
        dbg_req = 1'b1;
        dbg_we  = 1'b1;
        dbg_addr = 5'd12;
        @(negedge clk);
        check("abort_in_acc", 32'(core_stall), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ack", 32'(dbg_ack), 32'd0);
        rst     = 1'b0;
        dbg_req = 1'b0;
        check("abort_stall", 32'(core_stall), 32'(InitCycles > 0));
`ifdef REGFILE_INIT_EN
        check("abort_init_cnt", 32'(rf_rd), 32'd1);
`endif
        @(negedge clk);
        check("abort_ack_after", 32'(dbg_ack), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
